// File: rtl/ef_qspi_xip_reader.sv
// ef_qspi_xip_reader: AHB-Lite read-only XIP slave for QSPI NOR flash.
// Each read issues Fast Read Quad I/O (EBh) and stalls the bus until done.
module ef_qspi_xip_reader #(
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dout,
    output logic [3:0]  douten,
    input  logic [3:0]  din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0] CMD_EBH    = 8'hEB;
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        phase, phase_n;
    logic        pending, pending_n;
    logic [23:0] addr;
    logic [31:0] rdata;
    logic        busy;
    logic        accept;
    logic        start;
    logic        unused_ok;

    assign unused_ok = ^{HWDATA, HSIZE, HADDR[31:24],
                         HADDR[1:0], HTRANS[0]};

    assign busy = (state != S_IDLE) && (state != S_DONE);

    assign accept = HSEL & HREADY & HTRANS[1] &
                    (((state == S_IDLE) & ~pending) |
                     (state == S_DONE));
    assign start  = accept & ~HWRITE;

    assign HREADYOUT = ~(busy | pending);
    assign HRDATA    = rdata;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            phase   <= 1'b0;
            pending <= 1'b0;
            addr    <= 24'd0;
            rdata   <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            phase   <= phase_n;
            pending <= pending_n;
            if (start)
                addr <= {HADDR[23:2], 2'b00};
            // first byte lands in [7:0], high nibble of each byte first
            if ((state == S_DATA) && phase)
                rdata[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= din;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        phase_n   = 1'b0;
        pending_n = pending;
        sck       = 1'b0;
        ce_n      = 1'b1;
        dout      = 4'd0;
        douten    = 4'd0;
        if (busy) begin
            ce_n    = 1'b0;
            sck     = phase;
            phase_n = ~phase;
            cnt_n   = phase ? cnt + 4'd1 : cnt;
        end
        unique case (state)
            S_IDLE: begin
                if (pending || start) begin
                    state_n   = S_CMD;
                    cnt_n     = 4'd0;
                    pending_n = 1'b0;
                end
            end
            S_CMD: begin
                dout   = {3'b000, CMD_EBH[3'd7 - cnt[2:0]]};
                douten = 4'b0001;
                if (phase && (cnt == 4'd7)) begin
                    state_n = S_ADDR;
                    cnt_n   = 4'd0;
                end
            end
            S_ADDR: begin
                dout   = 4'(addr >> {3'd5 - cnt[2:0], 2'b00});
                douten = 4'b1111;
                if (phase && (cnt == 4'd5)) begin
                    state_n = S_MODE;
                    cnt_n   = 4'd0;
                end
            end
            S_MODE: begin
                douten = 4'b1111;
                if (phase && (cnt == 4'd1)) begin
                    state_n = (DUMMY_CYCLES != 0) ? S_DUMMY : S_DATA;
                    cnt_n   = 4'd0;
                end
            end
            S_DUMMY: begin
                if (phase && (cnt == DUMMY_LAST)) begin
                    state_n = S_DATA;
                    cnt_n   = 4'd0;
                end
            end
            S_DATA: begin
                if (phase && (cnt == 4'd7)) begin
                    state_n = S_DONE;
                    cnt_n   = 4'd0;
                end
            end
            S_DONE: begin
                // a read accepted here waits one IDLE gap before CMD
                state_n   = S_IDLE;
                cnt_n     = 4'd0;
                pending_n = start;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ef_qspi_xip_reader.sv
// Bench for ef_qspi_xip_reader: two builds (4 and 0 dummy cycles) against
// a pin-level flash model and a byte-array reference memory.
module tb_ef_qspi_xip_reader;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  hsel;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;

    logic        hrdy   [2];
    logic [31:0] hrd    [2];
    logic        sck    [2];
    logic        ce_n   [2];
    logic [3:0]  dout   [2];
    logic [3:0]  douten [2];

    logic [7:0]  mem [4096];
    logic [3:0]  dv  [64];
    logic        sv  [64];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 2; g++) begin : gm
        localparam int D = (g == 0) ? 4 : 0;
        logic [3:0]  din_m = 4'h0;
        int          pos   = 0;
        logic [7:0]  cmd   = 8'h00;
        logic [23:0] fa    = 24'h0;

        ef_qspi_xip_reader #(.DUMMY_CYCLES(D)) dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (hsel[g]),
            .HTRANS    (HTRANS),
            .HWRITE    (HWRITE),
            .HREADY    (hrdy[g]),
            .HSIZE     (HSIZE),
            .HADDR     (HADDR),
            .HWDATA    (HWDATA),
            .HREADYOUT (hrdy[g]),
            .HRDATA    (hrd[g]),
            .sck       (sck[g]),
            .ce_n      (ce_n[g]),
            .dout      (dout[g]),
            .douten    (douten[g]),
            .din       (din_m)
        );

        // capture command bits and address nibbles on rising sck
        always @(posedge sck[g] or posedge ce_n[g]) begin
            if (ce_n[g]) begin
                pos = 0;
            end else begin
                if (pos < 8)
                    cmd = {cmd[6:0], dout[g][0]};
                else if (pos < 14)
                    fa = {fa[19:0], dout[g]};
                pos++;
            end
        end

        // drive data nibbles on falling sck, mode-0 style
        always @(negedge sck[g]) begin
            int k;
            logic [7:0] b;
            if (pos >= 16 + D && pos < 24 + D) begin
                k = pos - 16 - D;
                b = mem[fa[11:0] + 12'(k / 2)];
                din_m = k[0] ? b[3:0] : b[7:4];
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {mem[b + 12'd3], mem[b + 12'd2],
                mem[b + 12'd1], mem[b]};
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input int g, input logic [31:0] a,
                           input int w, input string tag,
                           output int hi);
        int n;
        n  = 0;
        hi = 0;
        hsel[g] = 1'b1;
        HTRANS  = 2'b10;
        HWRITE  = 1'b0;
        HADDR   = a;
        HSIZE   = 3'($urandom_range(0, 2));
        tick();
        hsel   = 2'b00;
        HTRANS = 2'b00;
        while (hrdy[g] !== 1'b1 && n < 300) begin
            if (n < 64) begin
                dv[n] = douten[g];
                sv[n] = sck[g];
            end
            if (ce_n[g] === 1'b1)
                hi++;
            n++;
            tick();
        end
        chk({tag, " wait"}, n, w);
        chk({tag, " data"}, hrd[g], exp_word(a));
        chk({tag, " ce_n done"}, {31'd0, ce_n[g]}, 32'd1);
    endtask

    initial begin
        int hi;
        int n;
        for (int i = 0; i < 4096; i++)
            mem[i] = 8'($urandom);
        mem[12'h104] = 8'h11;
        mem[12'h105] = 8'h22;
        mem[12'h106] = 8'h33;
        mem[12'h107] = 8'h44;

        HRESETn = 1'b0;
        hsel    = 2'b00;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'd2;
        HADDR   = 32'd0;
        HWDATA  = 32'd0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk("rst ce_n", {31'd0, ce_n[g]}, 32'd1);
            chk("rst sck", {31'd0, sck[g]}, 32'd0);
            chk("rst douten", {28'd0, douten[g]}, 32'd0);
            chk("rst dout", {28'd0, dout[g]}, 32'd0);
            chk("rst hready", {31'd0, hrdy[g]}, 32'd1);
            chk("rst hrdata", hrd[g], 32'd0);
        end
        HRESETn = 1'b1;
        tick();

        do_read(0, 32'h0000_0106, 56, "single", hi);
        chk("single word", hrd[0], 32'h4433_2211);
        chk("single cmd", {24'd0, gm[0].cmd}, 32'h0000_00EB);
        chk("single addr", {8'd0, gm[0].fa}, 32'h0000_0104);
        chk("cmd douten", {28'd0, dv[0]}, 32'h1);
        chk("addr douten", {28'd0, dv[16]}, 32'hF);
        chk("mode douten", {28'd0, dv[30]}, 32'hF);
        chk("dummy douten", {28'd0, dv[32]}, 32'h0);
        chk("data douten", {28'd0, dv[44]}, 32'h0);
        chk("sck ph0", {31'd0, sv[0]}, 32'd0);
        chk("sck ph1", {31'd0, sv[1]}, 32'd1);
        tick();

        for (int i = 0; i < 2; i++) begin
            hsel[0] = 1'b1;
            HTRANS  = 2'b10;
            HWRITE  = 1'b1;
            HADDR   = $urandom;
            HWDATA  = $urandom;
            tick();
            hsel   = 2'b00;
            HTRANS = 2'b00;
            HWRITE = 1'b0;
            chk("wr hready", {31'd0, hrdy[0]}, 32'd1);
            n = 0;
            repeat (4) begin
                if (ce_n[0] !== 1'b1 || hrdy[0] !== 1'b1)
                    n++;
                tick();
            end
            chk("wr idle", n, 0);
            if (i == 0)
                do_read(0, 32'h0000_0204, 56, "pre-wr", hi);
        end

        do_read(0, 32'h0000_0100, 56, "b2b1", hi);
        do_read(0, 32'h0000_0104, 57, "b2b2", hi);
        chk("b2b ce_n high", hi + 1, 2);
        chk("b2b cmd", {24'd0, gm[0].cmd}, 32'h0000_00EB);
        tick();

        do_read(1, 32'h0000_0106, 48, "d0 single", hi);
        chk("d0 cmd", {24'd0, gm[1].cmd}, 32'h0000_00EB);
        chk("d0 data douten", {28'd0, dv[32]}, 32'h0);
        chk("d0 mode douten", {28'd0, dv[31]}, 32'hF);
        tick();

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = {20'd0, 12'($urandom)};
            do_read(i % 2, a, (i % 2 == 0) ? 56 : 48, "rand", hi);
            tick();
        end

        hsel[0] = 1'b1;
        HTRANS  = 2'b10;
        HWRITE  = 1'b0;
        HADDR   = 32'h0000_0300;
        tick();
        hsel   = 2'b00;
        HTRANS = 2'b00;
        n = 0;
        while (gm[0].pos < 23 && n < 200) begin
            n++;
            tick();
        end
        chk("reach data", {31'd0, (n < 200)}, 32'd1);
        chk("mid ce_n", {31'd0, ce_n[0]}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("arst ce_n", {31'd0, ce_n[0]}, 32'd1);
        chk("arst sck", {31'd0, sck[0]}, 32'd0);
        chk("arst douten", {28'd0, douten[0]}, 32'd0);
        chk("arst hready", {31'd0, hrdy[0]}, 32'd1);
        chk("arst hrdata", hrd[0], 32'd0);
        repeat (2) tick();
        HRESETn = 1'b1;
        tick();
        do_read(0, 32'h0000_0000, 56, "post-rst", hi);
        chk("post-rst addr", {8'd0, gm[0].fa}, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ef_qspi_xip_reader.md
# ef_qspi_xip_reader

AHB-Lite read-only slave that fetches 32-bit words from an external QSPI NOR flash using the Fast Read Quad I/O command (EBh). It is a hardware state machine, not a bit-banged engine. It drives the fr_* flash-reader port that the flash-writer mux passes to the pins when write mode is off. Each AHB read is stalled with HREADYOUT low until the word has been shifted in.

## Interface
- DUMMY_CYCLES, 4, SCK cycles of dummy after the mode byte; legal 0..15.
- HCLK  in  1  clock; all logic is on its rising edge.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- HSEL, HTRANS[1:0], HWRITE, HREADY, HSIZE[2:0]  in  AHB-Lite address-phase controls.
- HADDR  in  32  byte address; bits [23:2] are used.
- HWDATA  in  32  ignored.
- HREADYOUT  out  1  low while a read is in progress.
- HRDATA  out  32  read data; valid when HREADYOUT=1 in the DONE cycle.
- sck  out  1  flash clock, idle low (SPI mode 0).
- ce_n  out  1  flash chip select, active-low.
- dout  out  4  data to flash.
- douten  out  4  per-bit output enable (1 = drive).
- din  in  4  data from flash.

## Operation
- Accept: a transfer is accepted when HSEL & HREADY & HTRANS[1] are all 1 in IDLE or DONE.
- Accepted read: latch word address {HADDR[23:2], 2'b00} and start a flash transaction. HSIZE is ignored; a full word is always fetched.
- Accepted write: zero wait states, no effect.
- States: IDLE → CMD (8 SCK) → ADDR (6 SCK) → MODE (2 SCK) → DUMMY (DUMMY_CYCLES SCK; skipped if 0) → DATA (8 SCK) → DONE (1 HCLK) → IDLE.
- CMD: send 8'hEB MSB first on dout[0]. dout[3:1]=0, douten=4'b0001.
- ADDR: send 24-bit address as 6 nibbles, MSB nibble first, on dout[3:0]. douten=4'b1111.
- MODE: send 8'h00 as 2 nibbles (no continuous-read mode). douten=4'b1111.
- DUMMY and DATA: douten=4'b0000, dout=0.
- DATA: 8 nibbles form 4 bytes, high nibble of each byte first. Bytes are packed little-endian: first byte → HRDATA[7:0], fourth byte → HRDATA[31:24].
- SCK cycle = 2 HCLK:
  - phase 0: sck=0; dout is updated at the HCLK edge entering phase 0.
  - phase 1: sck=1; din is sampled at the HCLK edge that ends phase 1.
- ce_n is 0 in CMD through DATA and 1 in IDLE and DONE.
- A nibble counter and an SCK-phase bit select the current bit or nibble. State transitions occur at the end of the last phase 1 of each state.
- HRDATA holds the last fetched word until the next DATA phase overwrites it.

## Timing
- Reset values: sck=0, ce_n=1, dout=0, douten=0, HREADYOUT=1, HRDATA=0, state IDLE.
- Single read:
  - Cycle 0: address phase.
  - Cycles 1..2×(24+DUMMY_CYCLES): transaction, HREADYOUT=0. With defaults this is 56 wait states.
  - Next cycle: DONE, HREADYOUT=1, HRDATA valid.
- Back-to-back read accepted in DONE: one IDLE gap cycle, then CMD. HREADYOUT stays 0 through the gap. ce_n is high for exactly 2 HCLK (DONE + gap).
- A write accepted in DONE completes with zero wait states, and the next state is IDLE.
- HRESETn asserted mid-transaction: all outputs return to reset values immediately (ce_n=1 asynchronously). No data phase completes.
- While HREADYOUT=0, AHB guarantees no new address phase, so no request queueing is required.

## Test plan
- Reset: hold HRESETn=0 → ce_n=1, sck=0, douten=0, HREADYOUT=1, HRDATA=0.
- Single read:
  - Stimulus: read HADDR=0x0000_0106, flash model returns bytes 11,22,33,44.
  - Bits: dout[0] carries 11101011 in CMD; ADDR nibbles are 0,0,0,1,0,4.
  - Timing: 56 wait states.
  - Result: HRDATA=0x44332211.
- Write: write to any address → HREADYOUT stays 1, no ce_n activity.
- Back-to-back reads at 0x100 and 0x104 → ce_n high exactly 2 HCLK between them; each returns the model's data.
- Reset mid-DATA: assert HRESETn low at the 3rd data nibble → ce_n=1 at once. After release, a new read at 0x0 returns correct data.
- DUMMY_CYCLES=0 build: read → 48 wait states; DATA starts directly after MODE.
